// File: rtl/ebus_pkg.sv
// Shared EBUS definitions for the EBOX transfer sequencer.
// State encoding, function codes and bus field widths.
package ebus_pkg;

  localparam int CS_W = 7;
  localparam int F_W  = 3;
  localparam int D_W  = 36;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DEMAND,
    RELEASE
  } ebus_state_e;

  localparam logic [0:F_W-1] CONO  = 3'o0;
  localparam logic [0:F_W-1] CONI  = 3'o1;
  localparam logic [0:F_W-1] DATAO = 3'o2;
  localparam logic [0:F_W-1] DATAI = 3'o3;

endpackage

// File: rtl/ebus_xfer_timer.sv
// Loadable down-counter with zero flag.
// Shared by the setup hold and the demand timeout phases.
module ebus_xfer_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ebus_xfer_ctl.sv
// EBOX-side EBUS transfer sequencer (DATAO/CONO, DATAI/CONI).
// CS/F/demand handshake with no-response timeout.
module ebus_xfer_ctl
  import ebus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETUP_CYCLES   = 2,
  parameter int CNT_W          = 8
) (
  input  logic            eboxClk,
  input  logic            eboxReset,
  input  logic            start,
  input  logic            isWrite,
  input  logic [0:CS_W-1] devCS,
  input  logic [0:F_W-1]  func,
  input  logic            ebusXfer,
  input  logic [0:D_W-1]  ebusDataIn,
  output logic [0:CS_W-1] ebusCS,
  output logic [0:F_W-1]  ebusF,
  output logic            ebusDemand,
  output logic            CTL_adToEBUS_L,
  output logic            CTL_adToEBUS_R,
  output logic [0:D_W-1]  EBUS,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  ebus_state_e state_q, state_d;

  logic            wr_q, wr_d;
  logic [0:CS_W-1] cs_q, cs_d;
  logic [0:F_W-1]  f_q, f_d;
  logic            dem_q, dem_d;
  logic            drv_q, drv_d;
  logic [0:D_W-1]  data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            to_q, to_d;

  logic             t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_val;

  ebus_xfer_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (eboxClk),
    .rst      (eboxReset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      f_q     <= '0;
      dem_q   <= 1'b0;
      drv_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      f_q     <= f_d;
      dem_q   <= dem_d;
      drv_q   <= drv_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    f_d     = f_q;
    data_d  = data_q;
    done_d  = 1'b0;
    to_d    = to_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_val   = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_d    = isWrite;
          cs_d    = devCS;
          f_d     = func;
          to_d    = 1'b0;
          t_load  = 1'b1;
          t_val   = CNT_W'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (t_zero) begin
          t_load  = 1'b1;
          t_val   = CNT_W'(TIMEOUT_CYCLES - 1);
          state_d = DEMAND;
        end else begin
          t_dec = 1'b1;
        end
      end
      DEMAND: begin
        // An acknowledge on the last timeout cycle still counts as success.
        if (ebusXfer) begin
          if (!wr_q) data_d = ebusDataIn;
          state_d = RELEASE;
        end else if (t_zero) begin
          to_d    = 1'b1;
          state_d = RELEASE;
        end else begin
          t_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (!ebusXfer) begin
          done_d  = !to_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      cs_d = '0;
      f_d  = '0;
    end
    busy_d = (state_d != IDLE);
    dem_d  = (state_d == DEMAND);
    drv_d  = busy_d && wr_d;
  end

  assign ebusCS         = cs_q;
  assign ebusF          = f_q;
  assign ebusDemand     = dem_q;
  assign CTL_adToEBUS_L = drv_q;
  assign CTL_adToEBUS_R = drv_q;
  assign EBUS           = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Directed bench for ebus_xfer_ctl.
// Expected values are hand-derived from the transfer timing.
module tb_ebus_xfer_ctl;
  import ebus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        isWrite = 1'b0;
  logic [0:6]  devCS = '0;
  logic [0:2]  func = '0;
  logic        xfer = 1'b0;
  logic [0:35] din = '0;
  logic [0:6]  ebusCS;
  logic [0:2]  ebusF;
  logic        dem, adL, adR, busy, done, tout;
  logic [0:35] EBUS;

  int n_chk = 0;
  int n_pass = 0;
  int cyc;

  ebus_xfer_ctl dut (
    .eboxClk        (clk),
    .eboxReset      (rst),
    .start          (start),
    .isWrite        (isWrite),
    .devCS          (devCS),
    .func           (func),
    .ebusXfer       (xfer),
    .ebusDataIn     (din),
    .ebusCS         (ebusCS),
    .ebusF          (ebusF),
    .ebusDemand     (dem),
    .CTL_adToEBUS_L (adL),
    .CTL_adToEBUS_R (adR),
    .EBUS           (EBUS),
    .busy           (busy),
    .done           (done),
    .timeout        (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic wr, input logic [0:6] cs,
                    input logic [0:2] f);
    start = 1'b1; isWrite = wr; devCS = cs; func = f;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_cs", 64'(ebusCS), 0);
    chk("rst_dem", 64'(dem), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ebus", 64'(EBUS), 0);
    chk("rst_to", 64'(tout), 0);
    #12 rst = 1'b0;
    step();

    // 1: write
    go(1'b1, 7'o04, DATAO);
    chk("w_cs", 64'(ebusCS), 64'o04);
    chk("w_f", 64'(ebusF), 64'(DATAO));
    chk("w_adL", 64'(adL), 1);
    chk("w_adR", 64'(adR), 1);
    chk("w_dem0", 64'(dem), 0);
    chk("w_busy", 64'(busy), 1);
    step();
    chk("w_dem1", 64'(dem), 0);
    step();
    chk("w_dem2", 64'(dem), 1);
    step(); step(); step();
    chk("w_dem_hold", 64'(dem), 1);
    xfer = 1'b1;
    step();
    chk("w_dem_drop", 64'(dem), 0);
    chk("w_rel_cs", 64'(ebusCS), 64'o04);
    chk("w_rel_done", 64'(done), 0);
    xfer = 1'b0;
    step();
    chk("w_done", 64'(done), 1);
    chk("w_idle_busy", 64'(busy), 0);
    chk("w_idle_drv", 64'(adL), 0);
    chk("w_idle_cs", 64'(ebusCS), 0);
    step();
    chk("w_done_pulse", 64'(done), 0);

    // 2: read
    go(1'b0, 7'o10, DATAI);
    chk("r_adL", 64'(adL), 0);
    chk("r_f", 64'(ebusF), 64'(DATAI));
    step(); step();
    chk("r_dem", 64'(dem), 1);
    din = 36'h123456789; xfer = 1'b1;
    step();
    chk("r_ebus", 64'(EBUS), 64'h123456789);
    chk("r_adR", 64'(adR), 0);
    din = '0; xfer = 1'b0;
    step();
    chk("r_done", 64'(done), 1);
    chk("r_busy", 64'(busy), 0);
    step();
    chk("r_ebus_held", 64'(EBUS), 64'h123456789);

    // 3: timeout
    go(1'b1, 7'o20, CONO);
    step(); step();
    cyc = 0;
    while (dem && cyc < 100) begin
      cyc++;
      step();
    end
    chk("t_dem_cycles", 64'(cyc), 64);
    chk("t_flag", 64'(tout), 1);
    step();
    chk("t_no_done", 64'(done), 0);
    chk("t_busy", 64'(busy), 0);
    chk("t_ebus", 64'(EBUS), 64'h123456789);
    chk("t_sticky", 64'(tout), 1);

    // 4: acknowledge on the 64th demand cycle
    go(1'b0, 7'o30, DATAI);
    chk("b_to_clr", 64'(tout), 0);
    step(); step();
    for (int i = 0; i < 63; i++) step();
    chk("b_dem64", 64'(dem), 1);
    xfer = 1'b1; din = 36'hABCDEF012;
    step();
    chk("b_dem_drop", 64'(dem), 0);
    chk("b_to", 64'(tout), 0);
    chk("b_ebus", 64'(EBUS), 64'hABCDEF012);
    xfer = 1'b0; din = '0;
    step();
    chk("b_done", 64'(done), 1);

    // 5: start while busy ignored, then async reset in DEMAND
    go(1'b1, 7'o44, CONI);
    start = 1'b1; devCS = 7'o55;
    step();
    start = 1'b0;
    chk("i_cs", 64'(ebusCS), 64'o44);
    step();
    chk("i_dem", 64'(dem), 1);
    #2 rst = 1'b1;
    #1;
    chk("a_dem", 64'(dem), 0);
    chk("a_cs", 64'(ebusCS), 0);
    chk("a_drv", 64'(adL), 0);
    chk("a_busy", 64'(busy), 0);
    chk("a_ebus", 64'(EBUS), 0);
    step();
    rst = 1'b0;
    step();
    chk("a_idle_busy", 64'(busy), 0);
    chk("a_no_done", 64'(done), 0);

    // 6: stuck device
    go(1'b0, 7'o60, DATAI);
    step(); step();
    xfer = 1'b1; din = 36'h0F0F0F0F0;
    step();
    chk("s_dem", 64'(dem), 0);
    for (int i = 0; i < 5; i++) step();
    chk("s_busy", 64'(busy), 1);
    chk("s_cs", 64'(ebusCS), 64'o60);
    chk("s_no_done", 64'(done), 0);
    xfer = 1'b0;
    step();
    chk("s_done", 64'(done), 1);
    chk("s_idle", 64'(busy), 0);
    chk("s_ebus", 64'(EBUS), 64'h0F0F0F0F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ebus_xfer_ctl.md
Name: ebus_xfer_ctl

Overview:
- EBOX-side EBUS transfer sequencer for the DATAO/CONO and DATAI/CONI paths.
- Sits directly beside the EDP:
  - on writes it drives CTL_adToEBUS_L and CTL_adToEBUS_R, so the EDP puts AD onto EBUS;
  - on reads it captures the device-driven bus word and holds it on EBUS, so the EDP can load it into AR.
- Runs the controller-select / function / demand / transfer handshake and applies a no-response timeout.

Parameters:
- TIMEOUT_CYCLES, 64: demand cycles without ebusXfer before the transfer is aborted.
- SETUP_CYCLES, 2: cycles that CS and F (plus EBUS drive on writes) are held before demand asserts; minimum 1.
- CNT_W, 8: counter width. Must satisfy 2**CNT_W > max(TIMEOUT_CYCLES, SETUP_CYCLES).

Ports:
- eboxClk  in  1  EBOX clock; all state changes on posedge.
- eboxReset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- isWrite  in  1  1 = DATAO/CONO (EBOX drives), 0 = DATAI/CONI (device drives).
- devCS  in  [0:6]  device controller select, latched at start.
- func  in  [0:2]  EBUS function code, latched at start.
- ebusXfer  in  1  device transfer acknowledge.
- ebusDataIn  in  [0:35]  device-driven bus value.
- ebusCS  out  [0:6]  controller select to EBUS.
- ebusF  out  [0:2]  function to EBUS.
- ebusDemand  out  1  EBOX demand.
- CTL_adToEBUS_L  out  1  EDP drives AD bits 0:17 onto EBUS.
- CTL_adToEBUS_R  out  1  EDP drives AD bits 18:35 onto EBUS.
- EBUS  out  [0:35]  captured read data toward EDP; held until the next read capture.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (async, active-high):
  - all outputs 0, state IDLE, counter 0.
  - EBUS is cleared to 0, and timeout is cleared.
- IDLE:
  - start=1 latches devCS, func and isWrite, clears timeout and loads counter=SETUP_CYCLES-1.
  - Next state is SETUP. The start-to-CS latency is 1 cycle.
- SETUP:
  - ebusCS and ebusF show the latched values.
  - CTL_adToEBUS_L and CTL_adToEBUS_R = 1 iff write.
  - Counter decrements each cycle. At 0: go to DEMAND and load counter=TIMEOUT_CYCLES-1.
- DEMAND:
  - ebusDemand=1; CS, F and EBUS drive are held.
  - ebusXfer=1 seen at a posedge:
    - on a read, EBUS<=ebusDataIn on that same edge;
    - next state is RELEASE.
  - Otherwise, with counter=0: timeout<=1 and next state is RELEASE (abort). EBUS is unchanged.
  - Otherwise the counter decrements.
  - If ebusXfer and counter=0 occur in the same cycle, the transfer wins and no timeout is flagged.
- RELEASE:
  - ebusDemand=0; CS, F and EBUS drive remain asserted.
  - Wait until ebusXfer=0, then go to IDLE.
  - done pulses on that transition only if timeout=0.
  - The release wait is unbounded; a device stuck asserting ebusXfer keeps busy=1.
- IDLE outputs: ebusCS=0, ebusF=0, all drive enables 0.
- start while busy is ignored; no queuing.
- ebusXfer outside DEMAND and RELEASE is ignored.
- Reset mid-transfer: immediate return to IDLE; demand and drives drop asynchronously, and no done pulse is produced.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (ebus_pkg):
  - state enum {IDLE, SETUP, DEMAND, RELEASE};
  - EBUS function code constants (CONO, CONI, DATAO, DATAI);
  - CS width constant.
- One natural sub-module: ebus_xfer_timer, a loadable down-counter with a zero flag, used for both the setup and the timeout phases.

Test Plan:
1. Write, SETUP_CYCLES=2: start, isWrite=1, devCS=7'o04, func=DATAO. Required response:
   - CS and F asserted 1 cycle after start, with adToEBUS_L/R=1;
   - demand asserts 2 cycles later;
   - ebusXfer raised after 3 cycles: demand drops next cycle;
   - ebusXfer dropped: done pulses 1 cycle, busy=0, drives=0.
2. Read: start, isWrite=0, func=DATAI, device drives ebusDataIn=36'h123456789 with ebusXfer. Required response:
   - EBUS=36'h123456789 and still held after IDLE;
   - adToEBUS_L/R never asserted.
3. Timeout, TIMEOUT_CYCLES=64: no ebusXfer. Required response:
   - demand high for exactly 64 cycles, then drops;
   - timeout=1, no done pulse, EBUS unchanged;
   - a subsequent start clears timeout.
4. Boundary: ebusXfer arrives on the 64th demand cycle. Required response: treated as success, done=1, timeout=0.
5. Reset asserted mid-DEMAND: all outputs 0 immediately (async) and state is IDLE; start during busy earlier in the same run is ignored (devCS is not relatched).
6. Stuck device: ebusXfer held high after demand drops. Required response: busy stays 1 and CS stays asserted until ebusXfer falls, then done pulses.
